// File: rtl/tdm_env_pkg.sv
// Shared constants for the TDM envelope stage: default widths and the 3-bit
// envelope state encoding used by both the stage and its step logic.
package tdm_env_pkg;

  localparam int D_W_DEF        = 16;
  localparam int ENV_W_DEF      = 16;
  localparam int VOICE_BITS_DEF = 2;
  localparam int NUM_VOICES_DEF = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/tdm_env_step.sv
// Combinational ADSR step for one TDM slot: next state and envelope from the
// stored state/envelope, gate and rates. Define TDM_ENV_RETRIGGER_EN for hard
// retrigger (envelope restarts from zero when re-gated during release).
module tdm_env_step
  import tdm_env_pkg::*;
#(
  parameter int ENV_W = ENV_W_DEF
) (
  input  logic [2:0]       state_i,
  input  logic [ENV_W-1:0] env_i,
  input  logic             gate_i,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] decay_rate,
  input  logic [ENV_W-1:0] release_rate,
  input  logic [ENV_W-1:0] sustain_level,
  output logic [2:0]       state_o,
  output logic [ENV_W-1:0] env_o
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [ENV_W-1:0] atk_base;
  logic [ENV_W:0]   atk_sum;
  logic [ENV_W-1:0] atk_env;
  logic [ENV_W-1:0] dec_diff;
  logic [ENV_W-1:0] dec_env;
  logic [ENV_W-1:0] rel_env;

  always_comb begin
    atk_base = env_i;
`ifdef TDM_ENV_RETRIGGER_EN
    if (state_i == ST_RELEASE) atk_base = '0;
`endif
    atk_sum  = {1'b0, atk_base} + {1'b0, attack_rate};
    atk_env  = atk_sum[ENV_W] ? ENV_MAX : atk_sum[ENV_W-1:0];
    // dec_diff only meaningful while env_i is above the sustain level
    dec_diff = env_i - sustain_level;
    dec_env  = (dec_diff <= decay_rate) ? sustain_level : env_i - decay_rate;
    rel_env  = (env_i > release_rate) ? env_i - release_rate : '0;
  end

  always_comb begin
    state_o = ST_IDLE;
    env_o   = '0;
    if (!gate_i) begin
      if (state_i == ST_ATTACK || state_i == ST_DECAY ||
          state_i == ST_SUSTAIN || state_i == ST_RELEASE) begin
        env_o   = rel_env;
        state_o = (rel_env == '0) ? ST_IDLE : ST_RELEASE;
      end
    end else begin
      case (state_i)
        ST_IDLE, ST_RELEASE, ST_ATTACK: begin
          env_o   = atk_env;
          state_o = (atk_env == ENV_MAX) ? ST_DECAY : ST_ATTACK;
        end
        ST_DECAY: begin
          if (sustain_level >= env_i) begin
            env_o   = sustain_level;
            state_o = ST_SUSTAIN;
          end else begin
            env_o   = dec_env;
            state_o = (dec_env == sustain_level) ? ST_SUSTAIN : ST_DECAY;
          end
        end
        ST_SUSTAIN: begin
          env_o   = sustain_level;
          state_o = ST_SUSTAIN;
        end
        default: begin
          env_o   = '0;
          state_o = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/tdm_env_stage.sv
// Time-multiplexed ADSR envelope stage: per-voice state/envelope storage,
// signed sample scaling and registered outputs. Optional TDM_ENV_RETRIGGER_EN.
module tdm_env_stage
  import tdm_env_pkg::*;
#(
  parameter int D_W        = D_W_DEF,
  parameter int ENV_W      = ENV_W_DEF,
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int VOICE_BITS = VOICE_BITS_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [VOICE_BITS-1:0] vin,
  input  logic [D_W-1:0]        din,
  input  logic                  gate_i,
  input  logic [ENV_W-1:0]      attack_rate,
  input  logic [ENV_W-1:0]      decay_rate,
  input  logic [ENV_W-1:0]      release_rate,
  input  logic [ENV_W-1:0]      sustain_level,
  output logic [D_W-1:0]        dout,
  output logic [VOICE_BITS-1:0] vout,
  output logic                  en_o,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int P_W = D_W + ENV_W + 1;

  logic [2:0]       state_q [NUM_VOICES];
  logic [2:0]       state_d [NUM_VOICES];
  logic [ENV_W-1:0] env_q   [NUM_VOICES];
  logic [ENV_W-1:0] env_d   [NUM_VOICES];

  logic [D_W-1:0]        dout_q, dout_d;
  logic [VOICE_BITS-1:0] vout_q, vout_d;
  logic                  en_q,   en_d;

  logic                  vin_ok;
  logic [2:0]            cur_state, nxt_state;
  logic [ENV_W-1:0]      cur_env,   nxt_env;
  logic signed [P_W-1:0] prod;
  logic [D_W-1:0]        scaled;

  generate
    if (NUM_VOICES >= (1 << VOICE_BITS)) begin : g_vin_full
      assign vin_ok = 1'b1;
    end else begin : g_vin_cmp
      assign vin_ok = ({{(32-VOICE_BITS){1'b0}}, vin} < 32'(NUM_VOICES));
    end
  endgenerate

  assign cur_state = vin_ok ? state_q[vin] : ST_IDLE;
  assign cur_env   = vin_ok ? env_q[vin]   : '0;

  tdm_env_step #(.ENV_W(ENV_W)) u_step (
    .state_i      (cur_state),
    .env_i        (cur_env),
    .gate_i       (gate_i),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .state_o      (nxt_state),
    .env_o        (nxt_env)
  );

  // Envelope is treated as an unsigned Q0.ENV_W gain; scaling uses the pre-update value
  assign prod   = $signed({{(ENV_W+1){din[D_W-1]}}, din}) *
                  $signed({{(D_W+1){1'b0}}, cur_env});
  assign scaled = D_W'(prod >>> ENV_W);

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (vin_ok) begin
      state_d[vin] = nxt_state;
      env_d[vin]   = nxt_env;
    end
    vout_d = vin;
    dout_d = vin_ok ? scaled : '0;
    en_d   = vin_ok && (cur_state != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= ST_IDLE;
        env_q[i]   <= '0;
      end
      dout_q <= '0;
      vout_q <= '0;
      en_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      en_q    <= en_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_active
      assign voice_active[i] = (state_q[i] != ST_IDLE);
    end
  endgenerate

  assign dout = dout_q;
  assign vout = vout_q;
  assign en_o = en_q;

endmodule

// File: tb/tb_tdm_env_stage.sv
// Bench for tdm_env_stage: ADSR reference model, per-cycle output compare,
// directed envelope scenarios, then randomized TDM traffic.
module tb_tdm_env_stage;

  localparam int DW = 16;
  localparam int EW = 16;
  localparam int NV = 3;
  localparam int VB = 2;
  localparam int EMAX = (1 << EW) - 1;

  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [VB-1:0] vin;
  logic [DW-1:0] din;
  logic          gate_i;
  logic [EW-1:0] attack_rate, decay_rate, release_rate, sustain_level;
  logic [DW-1:0] dout;
  logic [VB-1:0] vout;
  logic          en_o;
  logic [NV-1:0] voice_active;

  int checks = 0;
  int errors = 0;

  int m_st  [NV];
  int m_env [NV];
  bit started = 0;
  int exp_dout, exp_vout, exp_va;
  bit exp_en;

  tdm_env_stage #(.D_W(DW), .ENV_W(EW), .NUM_VOICES(NV), .VOICE_BITS(VB)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .vin          (vin),
    .din          (din),
    .gate_i       (gate_i),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .dout         (dout),
    .vout         (vout),
    .en_o         (en_o),
    .voice_active (voice_active)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mscale(input int d, input int e);
    longint sd, p;
    sd = (d >= 32768) ? longint'(d) - 65536 : longint'(d);
    p  = sd * longint'(e);
    return int'((p >>> 16) & 64'hFFFF);
  endfunction

  function automatic void mstep(input int st, input int e, input bit g,
                                input int ar, input int dr, input int rr, input int sus,
                                output int nst, output int ne);
    int base;
    if (!g) begin
      if (st == M_IDLE) begin nst = M_IDLE; ne = 0; end
      else begin
        ne  = (e - rr < 0) ? 0 : e - rr;
        nst = (ne == 0) ? M_IDLE : M_REL;
      end
    end else if (st == M_SUS || (st == M_DEC && sus >= e)) begin
      nst = M_SUS; ne = sus;
    end else if (st == M_DEC) begin
      ne  = (e - dr > sus) ? e - dr : sus;
      nst = (ne == sus) ? M_SUS : M_DEC;
    end else begin
      base = e;
`ifdef TDM_ENV_RETRIGGER_EN
      if (st == M_REL) base = 0;
`endif
      ne  = (base + ar > EMAX) ? EMAX : base + ar;
      nst = (ne == EMAX) ? M_DEC : M_ATT;
    end
  endfunction

  // Reference model: advances on every active edge from the same inputs the DUT sees
  always @(posedge sys_clk) begin
    int v, nst, ne;
    started = 1;
    if (!sys_rst_n) begin
      for (int i = 0; i < NV; i++) begin m_st[i] = M_IDLE; m_env[i] = 0; end
      exp_dout = 0; exp_vout = 0; exp_en = 0;
    end else begin
      v = int'(vin);
      exp_vout = v;
      if (v < NV) begin
        exp_dout = mscale(int'(din), m_env[v]);
        exp_en   = (m_st[v] != M_IDLE);
        mstep(m_st[v], m_env[v], gate_i, int'(attack_rate), int'(decay_rate),
              int'(release_rate), int'(sustain_level), nst, ne);
        m_st[v] = nst; m_env[v] = ne;
      end else begin
        exp_dout = 0; exp_en = 0;
      end
    end
    exp_va = 0;
    for (int i = 0; i < NV; i++) if (m_st[i] != M_IDLE) exp_va |= (1 << i);
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("dout", dout, exp_dout);
      chk("vout", vout, exp_vout);
      chk("en_o", en_o, exp_en);
      chk("voice_active", voice_active, exp_va);
    end
  end

  task automatic slot(input int v, input int d, input bit g, input int ar,
                      input int dr, input int rr, input int sus);
    @(negedge sys_clk);
    vin = VB'(v); din = DW'(d); gate_i = g;
    attack_rate = EW'(ar); decay_rate = EW'(dr); release_rate = EW'(rr); sustain_level = EW'(sus);
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int pick_rate();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return int'($urandom_range(1, 255));
      2: return int'($urandom_range(256, 16'h3FFF));
      default: return int'($urandom_range(16'h4000, 16'hFFFF));
    endcase
  endfunction

  initial begin
    bit gate_r [4];
    int ar, dr, rr, sus;
    sys_rst_n = 1'b0; vin = '0; din = '0; gate_i = 1'b0;
    attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_en", en_o, 0);
    chk("rst_active", voice_active, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Attack ramp on voice 1
    slot(1, 16'h4000, 1, 16'h4000, 0, 0, 0);
    chk("atk_env0", m_env[1], 16'h4000);
    chk("atk_dout0", dout, 0);
    slot(1, 16'h4000, 1, 16'h4000, 0, 0, 0);
    chk("atk_env1", m_env[1], 16'h8000);
    chk("atk_dout1", dout, 16'h1000);
    slot(1, 16'h4000, 1, 16'h4000, 0, 0, 0);
    chk("atk_env2", m_env[1], 16'hC000);
    slot(1, 16'h4000, 1, 16'h4000, 0, 0, 0);
    chk("atk_env3", m_env[1], 16'hFFFF);
    chk("atk_state", m_st[1], M_DEC);
    chk("atk_active", voice_active, 3'b010);

    // Decay to sustain
    for (int k = 1; k <= 7; k++) begin
      slot(1, 0, 1, 0, 16'h1000, 0, 16'h8000);
      chk("dec_step", m_env[1], 16'hFFFF - k * 16'h1000);
    end
    slot(1, 0, 1, 0, 16'h1000, 0, 16'h8000);
    chk("dec_clamp", m_env[1], 16'h8000);
    chk("dec_state", m_st[1], M_SUS);
    slot(1, 0, 1, 0, 16'h1000, 0, 16'h6000);
    chk("sus_track", m_env[1], 16'h6000);
    slot(1, 0, 1, 0, 16'h1000, 0, 16'h8000);
    chk("sus_back", m_env[1], 16'h8000);

    // Scaling
    slot(1, 16'h8000, 1, 0, 0, 0, 16'h8000);
    chk("scale_neg", dout, 16'hC000);
    slot(2, 0, 1, 16'hFFFF, 0, 0, 0);
    slot(2, 16'h7FFF, 1, 0, 0, 0, 0);
    chk("scale_pos", dout, 16'h7FFE);

    // Release to idle on voice 1
    slot(1, 16'h4000, 0, 0, 0, 16'h3000, 0);
    chk("rel_env0", m_env[1], 16'h5000);
    slot(1, 16'h4000, 0, 0, 0, 16'h3000, 0);
    chk("rel_env1", m_env[1], 16'h2000);
    slot(1, 16'h4000, 0, 0, 0, 16'h3000, 0);
    chk("rel_env2", m_env[1], 0);
    chk("rel_state", m_st[1], M_IDLE);
    chk("rel_active_clr", voice_active[1], 0);
    chk("rel_en_last", en_o, 1);
    slot(1, 16'h4000, 0, 0, 0, 16'h3000, 0);
    chk("rel_en_next", en_o, 0);

    // Retrigger from release on voice 0
    slot(0, 0, 1, 16'h8000, 0, 0, 0);
    slot(0, 0, 0, 0, 0, 16'h3000, 0);
    chk("retrig_rel", m_env[0], 16'h5000);
    slot(0, 0, 1, 16'h1000, 0, 0, 0);
`ifdef TDM_ENV_RETRIGGER_EN
    chk("retrig_env", m_env[0], 16'h1000);
`else
    chk("retrig_env", m_env[0], 16'h6000);
`endif

    // Unused slot number
    slot(3, 16'h7FFF, 1, 16'hFFFF, 0, 0, 0);
    chk("oor_dout", dout, 0);
    chk("oor_en", en_o, 0);
    chk("oor_vout", vout, 3);

    // Reset with all voices sustaining
    for (int v = 0; v < NV; v++) begin
      slot(v, 16'h1234, 1, 16'hFFFF, 0, 0, 16'h8000);
      slot(v, 16'h1234, 1, 0, 16'hFFFF, 0, 16'h8000);
    end
    chk("all_sus", voice_active, 3'b111);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_vout", vout, 0);
    chk("mid_rst_en", en_o, 0);
    chk("mid_rst_active", voice_active, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int v = 0; v < NV; v++) slot(v, 16'h1234, 0, 0, 0, 16'h100, 0);
    chk("post_rst_active", voice_active, 0);

    // Randomized TDM traffic
    for (int i = 0; i < 4; i++) gate_r[i] = 0;
    ar = pick_rate(); dr = pick_rate(); rr = pick_rate(); sus = int'($urandom_range(0, EMAX));
    for (int n = 0; n < 5000; n++) begin
      int v;
      v = int'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) gate_r[v] = ~gate_r[v];
      if ($urandom_range(0, 31) == 0) ar = pick_rate();
      if ($urandom_range(0, 31) == 0) dr = pick_rate();
      if ($urandom_range(0, 31) == 0) rr = pick_rate();
      if ($urandom_range(0, 63) == 0) sus = int'($urandom_range(0, EMAX));
      @(negedge sys_clk);
      sys_rst_n = ($urandom_range(0, 599) != 0);
      vin = VB'(v); din = DW'($urandom()); gate_i = gate_r[v];
      attack_rate = EW'(ar); decay_rate = EW'(dr); release_rate = EW'(rr); sustain_level = EW'(sus);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1; gate_i = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
